// File: rtl/fanout_lane_arbiter.sv
// Round-robin arbiter sharing one 3-way fan-out lane among NREQ requesters, with a
// forced one-cycle gap between owners. Optional hold watchdog: FANOUT_ARB_TIMEOUT_EN.
module fanout_lane_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic [2:0]       lane_out,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]       lane_q, lane_d;

    logic             found;
    logic [IDX_W-1:0] sel;
    logic             owner_rel;
    logic             force_rel;

    // First requesting index, scanning circularly upward from rr_ptr.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[IDX_W'((int'(rr_ptr_q) + i) % NREQ)]) begin
                found = 1'b1;
                sel   = IDX_W'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    assign owner_rel = rel[owner_q] | ~req[owner_q];

`ifdef FANOUT_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    // A normal release on the same edge wins, so the watchdog only fires without one.
    assign force_rel = (state_q == GRANT) && !owner_rel && (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == GRANT) begin
            if (force_rel) begin
                timeout_d = 1'b1;
            end else if (!owner_rel && hold_cnt_q != 8'hFF) begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end else if (found) begin
            hold_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else if (ena) begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        lane_d   = (state_q == GRANT) ? {3{din[owner_q]}} : 3'b000;
        case (state_q)
            GRANT: begin
                if (owner_rel || force_rel) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    rr_ptr_d = IDX_W'((int'(owner_q) + 1) % NREQ);
                end
            end
            default: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
                    owner_d = sel;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            lane_q   <= 3'b000;
        end else if (ena) begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            lane_q   <= lane_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = (state_q == GRANT);
    assign lane_out = lane_q;

endmodule
